// File: rtl/spi_ram_responder_pkg.sv
// spi_ram_responder_pkg: shared states, command codes and decode helper
// for the SPI RAM responder.
package spi_ram_responder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    RD_DATA,
    WR_DATA,
    STATUS,
    IGNORE
  } state_t;

  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_RDSR   = 8'h05;
  localparam logic [7:0] CMD_WRSR   = 8'h01;
  localparam logic [7:0] MODE_RESET = 8'h40;

  // Map a received command byte to the state that handles it.
  function automatic state_t cmd_decode(
    input logic [7:0] c,
    input logic       en
  );
    state_t s;
    unique case (1'b1)
      (c == CMD_READ),
      (c == CMD_WRITE): s = ADDR;
      (en && (c == CMD_RDSR || c == CMD_WRSR)): s = STATUS;
      default: s = IGNORE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/spi_ram_responder_sync_edge.sv
// spi_sync_edge: 2-flop synchronizer with one-clk rise/fall pulses
// taken on the synchronized level.
module spi_sync_edge #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic meta;
  logic q;
  logic prev;

  // Two-stage synchronizer plus one delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= INIT;
      q    <= INIT;
      prev <= INIT;
    end else begin
      meta <= d;
      q    <= meta;
      prev <= q;
    end
  end

  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_ram_responder.sv
// spi_ram_responder: SPI mode-0 RAM target (READ 03 / WRITE 02).
// Define SPI_RAM_STATUS_EN to add the RDSR 05 / WRSR 01 mode register.
module spi_ram_responder
  import spi_ram_responder_pkg::*;
#(
  parameter int ADDR_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 spi_clk,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  input  logic                 spi_ce_n,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata,
  output logic                 mem_read,
  output logic                 mem_write
);

`ifdef SPI_RAM_STATUS_EN
  localparam logic STATUS_EN = 1'b1;
  logic [7:0] mode_reg;
  logic       st_wr;
`else
  localparam logic STATUS_EN = 1'b0;
`endif

  state_t      state;
  state_t      state_n;
  logic        clk_rise;
  logic        clk_fall;
  logic [1:0]  mosi_ff;
  logic [1:0]  ce_ff;
  logic        ce_prev;
  logic [1:0]  sync_ok;
  logic        armed;
  logic        ce_rise;
  logic        ce_fall;
  logic [3:0]  bit_cnt;
  logic [15:0] rx_sr;
  logic [15:0] rx_next;
  logic [7:0]  tx_sr;
  logic        is_write;
  logic        rd_load;
  logic        last_bit;
  logic        shifting_out;

  spi_sync_edge #(
    .INIT (1'b0)
  ) u_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (spi_clk),
    .rise  (clk_rise),
    .fall  (clk_fall)
  );

  // Plain synchronizers for mosi/ce_n; armed blocks a false ce_n
  // fall right after reset until ce_n has really been seen high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mosi_ff <= 2'b00;
      ce_ff   <= 2'b11;
      ce_prev <= 1'b1;
      sync_ok <= 2'b00;
      armed   <= 1'b0;
    end else begin
      mosi_ff <= {mosi_ff[0], spi_mosi};
      ce_ff   <= {ce_ff[0], spi_ce_n};
      ce_prev <= ce_ff[1];
      sync_ok <= {sync_ok[0], 1'b1};
      armed   <= armed | (sync_ok[1] & ce_ff[1]);
    end
  end

  assign ce_rise = ~ce_prev & ce_ff[1];
  assign ce_fall = ce_prev & ~ce_ff[1];
  assign shifting_out = (state == RD_DATA) || (state == STATUS);

  // Next-state decode; ce_n rising aborts from any state.
  always_comb begin
    state_n  = state;
    rx_next  = {rx_sr[14:0], mosi_ff[1]};
    last_bit = clk_rise &&
               (bit_cnt == ((state == ADDR) ? 4'd15 : 4'd7));
    if (ce_rise) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (ce_fall && armed) state_n = CMD;
        CMD:     if (last_bit) state_n = cmd_decode(rx_next[7:0], STATUS_EN);
        ADDR:    if (last_bit) state_n = is_write ? WR_DATA : RD_DATA;
`ifdef SPI_RAM_STATUS_EN
        STATUS:  if (last_bit && st_wr) state_n = IGNORE;
`endif
        default: state_n = state;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Shift registers, bit counter, memory strobes and address pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt   <= 4'd0;
      rx_sr     <= 16'd0;
      tx_sr     <= 8'd0;
      is_write  <= 1'b0;
      rd_load   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'd0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      spi_miso  <= 1'b0;
`ifdef SPI_RAM_STATUS_EN
      mode_reg  <= MODE_RESET;
      st_wr     <= 1'b0;
`endif
    end else begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      rd_load   <= mem_read;
      if (mem_write) mem_addr <= mem_addr + 1'b1;
      if (ce_rise || state == IDLE) begin
        bit_cnt  <= 4'd0;
        spi_miso <= 1'b0;
      end else begin
        if (clk_rise) begin
          rx_sr   <= rx_next;
          bit_cnt <= last_bit ? 4'd0 : bit_cnt + 4'd1;
        end
        if (clk_fall && shifting_out) begin
          spi_miso <= tx_sr[7];
          tx_sr    <= {tx_sr[6:0], 1'b0};
        end
        if (!shifting_out) spi_miso <= 1'b0;
        if (last_bit) begin
          unique case (state)
            CMD: begin
              is_write <= (rx_next[7:0] == CMD_WRITE);
`ifdef SPI_RAM_STATUS_EN
              st_wr <= (rx_next[7:0] == CMD_WRSR);
              tx_sr <= (rx_next[7:0] == CMD_RDSR) ? mode_reg : 8'd0;
`endif
            end
            ADDR: begin
              mem_addr <= rx_next[ADDR_BITS-1:0];
              mem_read <= !is_write;
            end
            RD_DATA: begin
              mem_addr <= mem_addr + 1'b1;
              mem_read <= 1'b1;
            end
            WR_DATA: begin
              mem_wdata <= rx_next[7:0];
              mem_write <= 1'b1;
            end
            STATUS: begin
`ifdef SPI_RAM_STATUS_EN
              if (st_wr) mode_reg <= rx_next[7:0];
              else       tx_sr    <= mode_reg;
`endif
            end
            default: ;
          endcase
        end
      end
      if (rd_load) tx_sr <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_spi_ram_responder.sv
// tb_spi_ram_responder: scoreboard bench for spi_ram_responder,
// covering read/write/wrap/abort/unknown-command/reset cases.
module tb_spi_ram_responder;
  import spi_ram_responder_pkg::*;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_clk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_ce_n = 1'b1;
  logic        spi_miso;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_read;
  logic        mem_write;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0]  mem [0:65535];
  logic        pre_we = 1'b0;
  logic [15:0] pre_addr = 16'h0;
  logic [7:0]  pre_data = 8'h0;

  logic [15:0] rd_obs[$];
  logic [23:0] wr_obs[$];
  int          both_cnt = 0;
  logic [15:0] exp_rd[$];
  logic [23:0] exp_wr[$];
  int          rd_idx = 0;
  int          wr_idx = 0;
  logic [15:0] ea;
  logic [23:0] ew;
  logic [7:0]  rx;

  spi_ram_responder #(
    .ADDR_BITS (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_clk   (spi_clk),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .spi_ce_n  (spi_ce_n),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_read  (mem_read),
    .mem_write (mem_write)
  );

  always #5 clk = ~clk;

  // Backing memory: read data valid one clk after mem_read.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (mem_read) mem_rdata <= mem[mem_addr];
  end

  // Strobe monitor: record what the DUT actually did.
  always @(negedge clk) begin
    if (mem_read) rd_obs.push_back(mem_addr);
    if (mem_write) wr_obs.push_back({mem_addr, mem_wdata});
    if (mem_read && mem_write) both_cnt++;
  end

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_addr = a;
    pre_data = d;
    pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic cs_begin();
    @(negedge clk);
    spi_ce_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (HALF) @(negedge clk);
    spi_ce_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] r);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = tx[i];
      repeat (HALF) @(negedge clk);
      spi_clk = 1'b1;
      r[i] = spi_miso;
      repeat (HALF) @(negedge clk);
      spi_clk = 1'b0;
    end
  endtask

  task automatic spi_bits(input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_clk = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk += 6;
    if (spi_miso !== 1'b0) begin
      n_fail++; $display("FAIL reset_miso: got %b want 0", spi_miso);
    end
    if (mem_addr !== 16'h0) begin
      n_fail++; $display("FAIL reset_addr: got %h want 0000", mem_addr);
    end
    if (mem_wdata !== 8'h0) begin
      n_fail++; $display("FAIL reset_wdata: got %h want 00", mem_wdata);
    end
    if (mem_read !== 1'b0) begin
      n_fail++; $display("FAIL reset_read: got %b want 0", mem_read);
    end
    if (mem_write !== 1'b0) begin
      n_fail++; $display("FAIL reset_write: got %b want 0", mem_write);
    end
    if (dut.state !== IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d want IDLE", dut.state);
    end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_read();
    poke(16'h1234, 8'hA5);
    poke(16'h1235, 8'h3C);
    poke(16'h1236, 8'h77);
    exp_rd.push_back(16'h1234);
    exp_rd.push_back(16'h1235);
    exp_rd.push_back(16'h1236);
    cs_begin();
    spi_byte(8'h03, rx);
    spi_byte(8'h12, rx);
    spi_byte(8'h34, rx);
    spi_byte(8'h00, rx);
    n_chk++;
    if (rx !== 8'hA5) begin
      n_fail++; $display("FAIL read_byte0: got %h want a5", rx);
    end
    spi_byte(8'h00, rx);
    n_chk++;
    if (rx !== 8'h3C) begin
      n_fail++; $display("FAIL read_byte1: got %h want 3c", rx);
    end
    cs_end();
    while (exp_rd.size() > 0) begin
      ea = exp_rd.pop_front();
      n_chk++;
      if (rd_idx >= rd_obs.size() || rd_obs[rd_idx] !== ea) begin
        n_fail++;
        $display("FAIL read_addr: got %h want %h",
                 rd_idx < rd_obs.size() ? rd_obs[rd_idx] : 16'hxxxx, ea);
      end
      rd_idx++;
    end
    n_chk++;
    if (rd_obs.size() != rd_idx || wr_obs.size() != wr_idx) begin
      n_fail++;
      $display("FAIL read_count: got %0d/%0d want %0d/%0d",
               rd_obs.size(), wr_obs.size(), rd_idx, wr_idx);
    end
    rd_idx = rd_obs.size();
    wr_idx = wr_obs.size();
  endtask

  task automatic test_write();
    exp_wr.push_back({16'h8000, 8'hDE});
    exp_wr.push_back({16'h8001, 8'hAD});
    cs_begin();
    spi_byte(8'h02, rx);
    spi_byte(8'h80, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'hDE, rx);
    spi_byte(8'hAD, rx);
    cs_end();
    while (exp_wr.size() > 0) begin
      ew = exp_wr.pop_front();
      n_chk++;
      if (wr_idx >= wr_obs.size() || wr_obs[wr_idx] !== ew) begin
        n_fail++;
        $display("FAIL write_strobe: got %h want %h",
                 wr_idx < wr_obs.size() ? wr_obs[wr_idx] : 24'hxxxxxx, ew);
      end
      wr_idx++;
    end
    n_chk++;
    if (wr_obs.size() != wr_idx || rd_obs.size() != rd_idx) begin
      n_fail++;
      $display("FAIL write_count: got %0d/%0d want %0d/%0d",
               wr_obs.size(), rd_obs.size(), wr_idx, rd_idx);
    end
    rd_idx = rd_obs.size();
    wr_idx = wr_obs.size();
  endtask

  task automatic test_wrap();
    poke(16'hFFFF, 8'h11);
    poke(16'h0000, 8'h22);
    exp_rd.push_back(16'hFFFF);
    exp_rd.push_back(16'h0000);
    exp_rd.push_back(16'h0001);
    cs_begin();
    spi_byte(8'h03, rx);
    spi_byte(8'hFF, rx);
    spi_byte(8'hFF, rx);
    spi_byte(8'h00, rx);
    n_chk++;
    if (rx !== 8'h11) begin
      n_fail++; $display("FAIL wrap_byte0: got %h want 11", rx);
    end
    spi_byte(8'h00, rx);
    n_chk++;
    if (rx !== 8'h22) begin
      n_fail++; $display("FAIL wrap_byte1: got %h want 22", rx);
    end
    cs_end();
    while (exp_rd.size() > 0) begin
      ea = exp_rd.pop_front();
      n_chk++;
      if (rd_idx >= rd_obs.size() || rd_obs[rd_idx] !== ea) begin
        n_fail++;
        $display("FAIL wrap_addr: got %h want %h",
                 rd_idx < rd_obs.size() ? rd_obs[rd_idx] : 16'hxxxx, ea);
      end
      rd_idx++;
    end
    n_chk++;
    if (rd_obs.size() != rd_idx || wr_obs.size() != wr_idx) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d/%0d want %0d/%0d",
               rd_obs.size(), wr_obs.size(), rd_idx, wr_idx);
    end
    rd_idx = rd_obs.size();
    wr_idx = wr_obs.size();
  endtask

  task automatic test_abort();
    cs_begin();
    spi_byte(8'h02, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h10, rx);
    spi_bits(5);
    cs_end();
    n_chk++;
    if (wr_obs.size() != wr_idx || rd_obs.size() != rd_idx) begin
      n_fail++;
      $display("FAIL abort_strobes: got %0d/%0d want %0d/%0d",
               wr_obs.size(), rd_obs.size(), wr_idx, rd_idx);
    end
    wr_idx = wr_obs.size();
    rd_idx = rd_obs.size();
    poke(16'h0010, 8'h5A);
    exp_rd.push_back(16'h0010);
    exp_rd.push_back(16'h0011);
    cs_begin();
    spi_byte(8'h03, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h10, rx);
    spi_byte(8'h00, rx);
    n_chk++;
    if (rx !== 8'h5A) begin
      n_fail++; $display("FAIL abort_next_read: got %h want 5a", rx);
    end
    cs_end();
    while (exp_rd.size() > 0) begin
      ea = exp_rd.pop_front();
      n_chk++;
      if (rd_idx >= rd_obs.size() || rd_obs[rd_idx] !== ea) begin
        n_fail++;
        $display("FAIL abort_addr: got %h want %h",
                 rd_idx < rd_obs.size() ? rd_obs[rd_idx] : 16'hxxxx, ea);
      end
      rd_idx++;
    end
    rd_idx = rd_obs.size();
  endtask

  task automatic test_unknown();
    logic [7:0] want_sr;
    logic [7:0] want_sr2;
`ifdef SPI_RAM_STATUS_EN
    want_sr  = 8'h40;
    want_sr2 = 8'h00;
`else
    want_sr  = 8'h00;
    want_sr2 = 8'h00;
`endif
    cs_begin();
    spi_byte(8'h9F, rx);
    spi_byte(8'h00, rx);
    n_chk++;
    if (rx !== 8'h00) begin
      n_fail++; $display("FAIL unknown_miso0: got %h want 00", rx);
    end
    spi_byte(8'h00, rx);
    n_chk++;
    if (rx !== 8'h00) begin
      n_fail++; $display("FAIL unknown_miso1: got %h want 00", rx);
    end
    cs_end();
    cs_begin();
    spi_byte(8'h05, rx);
    spi_byte(8'h00, rx);
    n_chk++;
    if (rx !== want_sr) begin
      n_fail++; $display("FAIL rdsr_reset: got %h want %h", rx, want_sr);
    end
    cs_end();
    cs_begin();
    spi_byte(8'h01, rx);
    spi_byte(8'h00, rx);
    cs_end();
    cs_begin();
    spi_byte(8'h05, rx);
    spi_byte(8'h00, rx);
    n_chk++;
    if (rx !== want_sr2) begin
      n_fail++; $display("FAIL rdsr_after_wrsr: got %h want %h", rx, want_sr2);
    end
    cs_end();
    n_chk++;
    if (rd_obs.size() != rd_idx || wr_obs.size() != wr_idx) begin
      n_fail++;
      $display("FAIL unknown_strobes: got %0d/%0d want %0d/%0d",
               rd_obs.size(), wr_obs.size(), rd_idx, wr_idx);
    end
    rd_idx = rd_obs.size();
    wr_idx = wr_obs.size();
  endtask

  task automatic test_reset_mid();
    poke(16'h0020, 8'hFF);
    exp_rd.push_back(16'h0020);
    cs_begin();
    spi_byte(8'h03, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h20, rx);
    spi_bits(4);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_chk += 6;
    if (spi_miso !== 1'b0) begin
      n_fail++; $display("FAIL midrst_miso: got %b want 0", spi_miso);
    end
    if (mem_addr !== 16'h0) begin
      n_fail++; $display("FAIL midrst_addr: got %h want 0000", mem_addr);
    end
    if (mem_wdata !== 8'h0) begin
      n_fail++; $display("FAIL midrst_wdata: got %h want 00", mem_wdata);
    end
    if (mem_read !== 1'b0) begin
      n_fail++; $display("FAIL midrst_read: got %b want 0", mem_read);
    end
    if (mem_write !== 1'b0) begin
      n_fail++; $display("FAIL midrst_write: got %b want 0", mem_write);
    end
    if (dut.state !== IDLE) begin
      n_fail++; $display("FAIL midrst_state: got %0d want IDLE", dut.state);
    end
    rst_n = 1'b1;
    repeat (HALF) @(negedge clk);
    spi_ce_n = 1'b1;
    repeat (10) @(negedge clk);
`ifdef SPI_RAM_STATUS_EN
    cs_begin();
    spi_byte(8'h05, rx);
    spi_byte(8'h00, rx);
    n_chk++;
    if (rx !== 8'h40) begin
      n_fail++; $display("FAIL midrst_mode: got %h want 40", rx);
    end
    cs_end();
`endif
    exp_rd.push_back(16'h0020);
    exp_rd.push_back(16'h0021);
    cs_begin();
    spi_byte(8'h03, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h20, rx);
    spi_byte(8'h00, rx);
    n_chk++;
    if (rx !== 8'hFF) begin
      n_fail++; $display("FAIL midrst_recover: got %h want ff", rx);
    end
    cs_end();
    while (exp_rd.size() > 0) begin
      ea = exp_rd.pop_front();
      n_chk++;
      if (rd_idx >= rd_obs.size() || rd_obs[rd_idx] !== ea) begin
        n_fail++;
        $display("FAIL midrst_addr_seq: got %h want %h",
                 rd_idx < rd_obs.size() ? rd_obs[rd_idx] : 16'hxxxx, ea);
      end
      rd_idx++;
    end
    n_chk += 2;
    if (rd_obs.size() != rd_idx || wr_obs.size() != wr_idx) begin
      n_fail++;
      $display("FAIL midrst_count: got %0d/%0d want %0d/%0d",
               rd_obs.size(), wr_obs.size(), rd_idx, wr_idx);
    end
    if (both_cnt !== 0) begin
      n_fail++; $display("FAIL both_strobes: got %0d want 0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_wrap();
    test_abort();
    test_unknown();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_ram_responder.md
SPI_RAM_RESPONDER -- requirements
Module: spi_ram_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 16, width of the byte address into backing memory (1..16).
REQ-002 SHALL have port clk  input  1  system clock; all logic on posedge clk.
REQ-003 SHALL have port rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port spi_clk  input  1  SPI clock from initiator, mode 0, asynchronous to clk.
REQ-005 SHALL have port spi_mosi  input  1  serial data in, MSB first.
REQ-006 SHALL have port spi_miso  output  1  serial data out, MSB first.
REQ-007 SHALL have port spi_ce_n  input  1  chip enable, active low.
REQ-008 SHALL have port mem_addr  output  ADDR_BITS  backing memory byte address.
REQ-009 SHALL have port mem_wdata  output  8  backing memory write data.
REQ-010 SHALL have port mem_rdata  input  8  backing memory read data, valid one clk after mem_read.
REQ-011 SHALL have port mem_read  output  1  one-clk read strobe.
REQ-012 SHALL have port mem_write  output  1  one-clk write strobe.

Function
REQ-013 SHALL pass spi_clk, spi_mosi, spi_ce_n through 2-flop synchronizers; rising/falling edges detected on synchronized spi_clk; supported spi_clk half-period >= 4 clk.
REQ-014 SHALL sample spi_mosi on detected rising edges and update spi_miso on detected falling edges.
REQ-015 SHALL implement states IDLE, CMD, ADDR, RD_DATA, WR_DATA, STATUS, IGNORE.
REQ-016 IDLE -> CMD on synchronized spi_ce_n falling; bit counter cleared.
REQ-017 CMD: after 8 bits, 0x03 -> ADDR (read), 0x02 -> ADDR (write), any other -> IGNORE.
REQ-018 ADDR: shift 16 bits; mem_addr = low ADDR_BITS of received address; read -> RD_DATA, write -> WR_DATA.
REQ-019 RD_DATA: mem_read pulsed on clk after last address bit rising edge; mem_rdata captured next clk into tx shift register; bit 7 driven on following falling edge.
REQ-020 RD_DATA: after 8th data rising edge, mem_addr increments and next mem_read pulses; continuous streaming with no gap.
REQ-021 WR_DATA: after 8th data rising edge, mem_wdata = received byte, mem_write pulses one clk at current mem_addr, then mem_addr increments.
REQ-022 mem_addr increments modulo 2^ADDR_BITS (all-ones wraps to 0).
REQ-023 IGNORE: no memory strobes, spi_miso held 0 until spi_ce_n high.
REQ-024 spi_miso SHALL be 0 outside RD_DATA and STATUS.
REQ-025 Synchronized spi_ce_n rising in any state -> IDLE next clk; partial bytes discarded, no mem_write for incomplete byte, spi_miso 0.
REQ-026 mem_read and mem_write never asserted in same clk.

Reset
REQ-027 rst_n low on posedge clk SHALL force IDLE, spi_miso 0, mem_addr 0, mem_wdata 0, mem_read 0, mem_write 0, counters and shift registers 0, synchronizers to idle (spi_clk 0, spi_ce_n 1).
REQ-028 Reset mid-transaction SHALL abort without memory strobe; new transaction needs spi_ce_n high then low.

Configuration
REQ-029 With macro SPI_RAM_STATUS_EN defined: command 0x05 -> STATUS, shifts 8-bit mode register out; 0x01 -> receives 8 bits into mode register; mode register resets to 0x40.
REQ-030 Without SPI_RAM_STATUS_EN: 0x05 and 0x01 treated as unknown (IGNORE), no mode register.

Structure
REQ-031 Shared package SHALL hold state enumeration and command constants (CMD_READ 0x03, CMD_WRITE 0x02, CMD_RDSR 0x05, CMD_WRSR 0x01, MODE_RESET 0x40).
REQ-032 One sub-module, spi_sync_edge: 2-flop synchronizer plus rise/fall pulse generation, instanced for spi_clk; plain synchronizer for mosi/ce_n.

Verification
REQ-033 Read: mem[0x1234]=0xA5, mem[0x1235]=0x3C; send 03 12 34 + 16 clocks -> MISO 0xA5 then 0x3C; mem_read at 0x1234, 0x1235.
REQ-034 Write: send 02 80 00 DE AD -> mem_write 0xDE at 0x8000, 0xAD at 0x8001, exactly two strobes.
REQ-035 Wrap: ADDR_BITS=16, read at 0xFFFF for 2 bytes -> mem_read addresses 0xFFFF then 0x0000.
REQ-036 Abort: 02 00 10 then 5 bits, ce_n high -> zero mem_write; next transaction 03 00 10 decodes normally.
REQ-037 Unknown command 0x9F + 16 clocks -> MISO 0, no strobes; with SPI_RAM_STATUS_EN, 05 -> 0x40, 01 00 then 05 -> 0x00.
REQ-038 Reset asserted mid-read byte -> all outputs 0 next clk, state IDLE.
